// File: rtl/prog_loader_if.sv
// Program byte-stream load channel: valid/ready handshake with a last-byte qualifier.
interface prog_loader_if;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_last;
  logic       load_ready;

  modport master (output load_valid, load_data, load_last, input load_ready);
  modport slave  (input load_valid, load_data, load_last, output load_ready);
endinterface

// File: rtl/prog_loader.sv
// Loads a program byte-stream into instruction memory, holds the core in reset until done,
// then serves input_ins = mem[pc]. Optional checksum trailer: define PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256,
  parameter logic [7:0]  FILL   = 8'h00
) (
  input  logic              clk,
  input  logic              CLB,
  prog_loader_if.slave      ld,
  input  logic              reload,
  input  logic [ADDR_W-1:0] pc,
  output logic [7:0]        input_ins,
  output logic              core_rst_n,
  output logic              done,
  output logic [ADDR_W:0]   length,
  output logic              overflow,
  output logic              csum_err
);
  typedef enum logic [2:0] {ST_RST, ST_LOAD, ST_RELEASE, ST_RUN, ST_ERROR} state_e;

  state_e          state_q, state_d;
  logic [7:0]      mem [DEPTH];
  logic [ADDR_W:0] len_q, len_d;  // also serves as the write pointer
  logic            rdy_q, rdy_d;
  logic            crn_q, crn_d;
  logic            done_q, done_d;
  logic            ovf_q, ovf_d;
  logic            accept, restart, at_top, last_ok, store;

  assign accept  = ld.load_valid && rdy_q;
  assign restart = reload && (state_q == ST_RUN || state_q == ST_ERROR);
  assign at_top  = (len_q == (ADDR_W+1)'(DEPTH-1));

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
  logic       cerr_q, cerr_d;

  // The last byte is a trailer that balances the running sum to zero; it is never stored.
  assign last_ok = (8'(sum_q + ld.load_data) == 8'h00);
  assign store   = accept && !ld.load_last;

  always_ff @(posedge clk or negedge CLB) begin
    if (!CLB) begin
      sum_q  <= '0;
      cerr_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cerr_q <= cerr_d;
    end
  end

  always_comb begin
    sum_d  = sum_q;
    cerr_d = cerr_q;
    if (restart) begin
      sum_d  = '0;
      cerr_d = 1'b0;
    end else if (accept) begin
      sum_d = 8'(sum_q + ld.load_data);
      if (ld.load_last && !last_ok) cerr_d = 1'b1;
    end
  end

  assign csum_err = cerr_q;
`else
  assign last_ok  = 1'b1;
  assign store    = accept;
  assign csum_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge CLB) begin
    if (!CLB) begin
      state_q <= ST_RST;
      len_q   <= '0;
      rdy_q   <= 1'b0;
      crn_q   <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      rdy_q   <= rdy_d;
      crn_q   <= crn_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (store) mem[len_q[ADDR_W-1:0]] <= ld.load_data;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RST:     state_d = ST_LOAD;
      ST_LOAD: begin
        if (accept) begin
          if (ld.load_last)  state_d = last_ok ? ST_RELEASE : ST_ERROR;
          else if (at_top)   state_d = ST_ERROR;
        end
      end
      ST_RELEASE: state_d = ST_RUN;
      ST_RUN,
      ST_ERROR:   if (reload) state_d = ST_LOAD;
      default:    state_d = ST_RST;
    endcase
  end

  // Registered outputs lag the state by one edge, so core reset releases two edges after the last byte.
  always_comb begin
    len_d = len_q;
    ovf_d = ovf_q;
    if (restart) begin
      len_d = '0;
      ovf_d = 1'b0;
    end else if (store) begin
      len_d = len_q + (ADDR_W+1)'(1);
      if (!ld.load_last && at_top) ovf_d = 1'b1;
    end
    rdy_d  = (state_q == ST_LOAD) && (state_d == ST_LOAD);
    crn_d  = (state_q == ST_RUN) && !reload;
    done_d = crn_d;
    input_ins = FILL;
    if (state_q == ST_RUN && {1'b0, pc} < len_q) input_ins = mem[pc];
  end

  assign ld.load_ready = rdy_q;
  assign core_rst_n    = crn_q;
  assign done          = done_q;
  assign length        = len_q;
  assign overflow      = ovf_q;
endmodule

// File: tb/tb_prog_loader.sv
// Directed-plus-random bench for prog_loader against a queue-based program model.
module tb_prog_loader;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DEPTH  = 256;
  localparam logic [7:0]  FILL   = 8'hEE;
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              CLB = 1'b0;
  logic              reload = 1'b0;
  logic [ADDR_W-1:0] pc = '0;
  logic [7:0]        input_ins;
  logic              core_rst_n, done, overflow, csum_err;
  logic [ADDR_W:0]   length;

  prog_loader_if ld();

  prog_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .FILL(FILL)) dut (
    .clk(clk), .CLB(CLB), .ld(ld), .reload(reload), .pc(pc),
    .input_ins(input_ins), .core_rst_n(core_rst_n), .done(done),
    .length(length), .overflow(overflow), .csum_err(csum_err)
  );

  always #5 clk = ~clk;

  int unsigned n_chk = 0, n_pass = 0, sent = 0;
  logic [7:0]  stream[$];
  logic [7:0]  prog[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) begin n_pass++; end
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic check_reset();
    chk("rst_ready", ld.load_ready, 0);
    chk("rst_core_rst_n", core_rst_n, 0);
    chk("rst_done", done, 0);
    chk("rst_length", length, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_csum_err", csum_err, 0);
    chk("rst_input_ins", input_ins, FILL);
  endtask

  task automatic send(input logic [7:0] b, input bit lst, input int unsigned gap);
    int unsigned w = 0;
    repeat (gap) begin @(posedge clk); #1; end
    if (gap > 0) chk("gap_length_hold", length, sent);
    ld.load_valid = 1'b1;
    ld.load_data  = b;
    ld.load_last  = lst;
    while (ld.load_ready !== 1'b1 && w < 40) begin @(posedge clk); #1; w++; end
    if (w >= 40) chk("ready_timeout", ld.load_ready, 1);
    @(posedge clk); #1;
    ld.load_valid = 1'b0;
    ld.load_last  = 1'b0;
    sent++;
  endtask

  task automatic make_stream(input int unsigned n);
    logic [7:0] s = 8'h00;
    logic [7:0] b;
    stream.delete();
    for (int unsigned i = 0; i < n; i++) begin
      b = 8'($urandom);
      s = 8'(s + b);
      stream.push_back(b);
    end
    if (CSUM) stream.push_back(8'(8'h00 - s));
  endtask

  // Model: stored bytes are the stream minus a checksum trailer; success iff trailer balances.
  task automatic run_stream(input bit gaps);
    logic [7:0]  s = 8'h00;
    int unsigned n = stream.size();
    int unsigned g;
    bit          ok;
    sent = 0;
    prog.delete();
    foreach (stream[i]) begin
      s = 8'(s + stream[i]);
      if (!(CSUM && i == n - 1)) prog.push_back(stream[i]);
    end
    ok = !CSUM || (s == 8'h00);
    for (int unsigned i = 0; i < n; i++) begin
      g = gaps ? ((i == 1) ? 5 : $urandom_range(0, 2)) : 0;
      send(stream[i], i == n - 1, g);
    end
    chk("ready_after_last", ld.load_ready, 0);
    @(posedge clk); #1;
    chk("core_rst_n_e1", core_rst_n, 0);
    @(posedge clk); #1;
    chk("core_rst_n_e2", core_rst_n, ok);
    chk("done_e2", done, ok);
    chk("length", length, prog.size());
    chk("csum_err", csum_err, !ok);
    chk("overflow_clear", overflow, 0);
  endtask

  task automatic check_reads();
    for (int unsigned p = 0; p <= prog.size() + 1 && p < (1 << ADDR_W); p++) begin
      pc = ADDR_W'(p);
      @(negedge clk);
      chk("input_ins", input_ins, (p < prog.size()) ? prog[p] : FILL);
    end
    pc = '0;
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
    prog.delete();
    chk("reload_done", done, 0);
    chk("reload_core_rst_n", core_rst_n, 0);
    chk("reload_length", length, 0);
    chk("reload_overflow", overflow, 0);
    chk("reload_csum_err", csum_err, 0);
    chk("reload_ready_e0", ld.load_ready, 0);
    @(posedge clk); #1;
    chk("reload_ready_e1", ld.load_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ld.load_valid = 1'b0;
    ld.load_data  = 8'h00;
    ld.load_last  = 1'b0;
    #2;
    check_reset();
    @(negedge clk); CLB = 1'b1;
    @(posedge clk); #1;
    chk("first_load_ready_e1", ld.load_ready, 0);
    @(posedge clk); #1;
    chk("first_load_ready_e2", ld.load_ready, 1);

    // Directed three-byte program
    stream.delete();
    if (CSUM) begin stream.push_back(8'h10); stream.push_back(8'h20); stream.push_back(8'hD0); end
    else      begin stream.push_back(8'h12); stream.push_back(8'h34); stream.push_back(8'h56); end
    run_stream(0);
    check_reads();

    // Random program with idle gaps, including a 5-cycle gap after byte 1
    do_reload();
    make_stream(6);
    run_stream(1);
    check_reads();

    // Single-instruction reload
    do_reload();
    stream.delete();
    stream.push_back(8'hAA);
    if (CSUM) stream.push_back(8'h56);
    run_stream(0);
    check_reads();

    // A few random-length programs
    for (int k = 0; k < 3; k++) begin
      do_reload();
      make_stream($urandom_range(1, 40));
      run_stream($urandom_range(0, 1) == 1);
      check_reads();
    end

    // Overflow: DEPTH bytes without last, then a further byte offered
    do_reload();
    sent = 0;
    for (int unsigned i = 0; i < DEPTH; i++) send(8'($urandom), 1'b0, 0);
    chk("ovf_overflow", overflow, 1);
    chk("ovf_length", length, DEPTH);
    chk("ovf_ready", ld.load_ready, 0);
    ld.load_valid = 1'b1;
    ld.load_data  = 8'h5A;
    repeat (3) begin @(posedge clk); #1; end
    ld.load_valid = 1'b0;
    chk("ovf_length_hold", length, DEPTH);
    chk("ovf_core_rst_n", core_rst_n, 0);
    chk("ovf_done", done, 0);
    chk("ovf_ready_hold", ld.load_ready, 0);
    chk("ovf_sticky", overflow, 1);
    do_reload();

    if (CSUM) begin
      stream.delete();
      stream.push_back(8'h10); stream.push_back(8'h20); stream.push_back(8'hD1);
      run_stream(0);
      repeat (2) begin @(posedge clk); #1; end
      chk("csum_core_rst_n_hold", core_rst_n, 0);
      chk("csum_err_sticky", csum_err, 1);
      do_reload();
    end

    // Reset asserted mid-stream, then a fresh four-byte load
    make_stream(4);
    sent = 0;
    send(stream[0], 1'b0, 0);
    send(stream[1], 1'b0, 0);
    CLB = 1'b0;
    #1;
    check_reset();
    @(negedge clk); CLB = 1'b1;
    @(posedge clk); #1;
    chk("rerst_ready_e1", ld.load_ready, 0);
    @(posedge clk); #1;
    chk("rerst_ready_e2", ld.load_ready, 1);
    make_stream(4);
    run_stream(0);
    check_reads();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/prog_loader.md
# prog_loader

Program-memory loader and instruction server for the 8-bit accumulator core. It accepts a program byte-stream over a valid/ready handshake and stores it in an internal instruction memory. It holds the core in reset until loading completes, then returns the instruction at the core's `pc` on the core's `input_ins` bus. It is the supplying end of the core's fetch interface: it consumes `pc` and produces `input_ins`.

## Interface
- `ADDR_W`, default 8: address width; must match the core `pc` width.
- `DEPTH`, default 256: memory entries; must be ≤ 2^ADDR_W.
- `FILL`, default 8'h00: instruction returned for addresses not loaded.
- `clk` input 1: single clock, rising edge.
- `CLB` input 1: reset, asynchronous, active-low.
- `load_valid` input 1: `load_data` is valid.
- `load_data` input 8: program byte.
- `load_last` input 1: qualifies the final byte of the stream.
- `load_ready` output 1: loader can accept a byte.
- `reload` input 1: single-cycle request to restart loading.
- `pc` input ADDR_W: core program counter.
- `input_ins` output 8: instruction to the core.
- `core_rst_n` output 1: drives the core's `CLB`; active-low.
- `done` output 1: program loaded and core running.
- `length` output ADDR_W+1: number of stored bytes.
- `overflow` output 1: stream exceeded `DEPTH`; sticky until reload or reset.
- `csum_err` output 1: checksum mismatch; sticky until reload or reset.

## Operation
- States: RST, LOAD, RELEASE, RUN, ERROR.
- Reset values, with `CLB` low: state RST, write pointer 0, `length` 0, `load_ready` 0, `core_rst_n` 0, `done` 0, `overflow` 0, `csum_err` 0, `input_ins` = `FILL`. Memory contents are not reset.
- RST → LOAD on the first clock edge after `CLB` deasserts.
- LOAD:
  - `load_ready` is 1.
  - A byte is accepted on an edge where `load_valid` and `load_ready` are both 1. The byte is written to `mem[wr_ptr]`, then `wr_ptr` and `length` increment.
  - An accepted byte with `load_last` = 1 → RELEASE.
  - An accepted byte at `wr_ptr` = DEPTH-1 with `load_last` = 0 is still stored, `length` becomes DEPTH, `overflow` is set to 1 → ERROR.
  - Edges where `load_valid` is 0 are idle; state and pointer are unchanged.
- RELEASE: lasts exactly one cycle, with `core_rst_n` still 0, then → RUN.
- RUN:
  - `core_rst_n` = 1 and `done` = 1.
  - `input_ins` = `mem[pc]` when `pc` < `length`, otherwise `FILL`. The read is combinational.
- ERROR: `core_rst_n` = 0, `done` = 0, `load_ready` = 0. The block stays here until `reload` or reset.
- `reload` in RUN or ERROR has the same effect:
  - → LOAD next edge.
  - `core_rst_n` = 0, `done` = 0.
  - `wr_ptr`, `length`, `overflow`, `csum_err` all cleared.
- `reload` in LOAD, RELEASE or RST is ignored.
- Outside RUN, `input_ins` = `FILL`.
- Asserting `CLB` at any point (including mid-stream) returns immediately to the reset values. The partial load is discarded by setting `length` to 0.

## Timing
- `load_ready`, `core_rst_n`, `done`, `length`, `overflow` and `csum_err` are all registered.
- Edge E accepts the byte with `load_last`:
  - `load_ready` falls after E.
  - `core_rst_n` and `done` rise after edge E+2.
  - The core's first fetch, at `pc` = 0, is served combinationally with no wait states.
- Throughput is one byte per cycle.
- `input_ins` changes in the same cycle as `pc`, so it is valid before the next rising edge for the core's IR load.
- Edge accepting `reload`: `core_rst_n` is 0 after that edge; `load_ready` is 1 from the following edge.

## Configuration
- Macro: `PROG_LOADER_CHECKSUM_EN`.
- Defined:
  - The byte carrying `load_last` is a checksum and is not stored.
  - The 8-bit sum of all stream bytes, checksum included, must equal 8'h00.
  - If it does → RELEASE.
  - If it does not → ERROR with `csum_err` = 1.
  - Overflow → ERROR as above.
  - A one-byte stream gives `length` 0.
- Undefined: the `load_last` byte is stored as program data, and `csum_err` is tied to 0.

## Test plan
- Load stream 8'h12, 8'h34, 8'h56 (last on 8'h56, macro off):
  - `length` = 3.
  - `core_rst_n` rises 2 edges after the last accept.
  - `pc` = 0/1/2 → `input_ins` = 12/34/56.
  - `pc` = 3 → `FILL`.
- Hold `load_valid` low for 5 cycles between bytes 1 and 2: no write occurs, pointer holds, final memory matches the gap-free load.
- Stream 257 bytes into `DEPTH` = 256 with no `load_last`: `overflow` = 1 after byte 256, state ERROR, `core_rst_n` stays 0, `load_ready` = 0.
- Macro on:
  - Stream 8'h10, 8'h20, 8'hD0(last): sum is 0 → RUN, `length` = 2.
  - Repeat with last byte 8'hD1: `csum_err` = 1, `core_rst_n` stays 0.
- In RUN, pulse `reload`, then load 8'hAA(last):
  - `done` drops the edge after `reload`.
  - Then RUN again with `length` = 1 and `mem[0]` = 8'hAA.
- Assert `CLB` after 2 of 4 bytes:
  - All outputs return to reset values at once.
  - After release, a fresh 4-byte load yields `length` = 4.
